nor_sweep_ctrl: RTL
===================

Name: nor_sweep_ctrl

Overview:
Sequencer and self-checker for the 3-input NOR-only function block F = x'z + xy'. On a start request it drives all 8 input vectors {x,y,z} = 0..7 into the function block in ascending order. It holds each vector for a programmable settle time, samples F, and compares it against an expected truth table. It reports pass/fail, the error count and the first failing vector, and sits between a test/bring-up host and the combinational function block.

Parameters:
DWELL, 4, settle cycles each vector is held before sampling; legal range >= 1
EXP_TT, 8'h3A, expected truth table; bit i = expected F for vector i = {x,y,z}

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a sweep; accepted only in IDLE
abort  input  1  cancel sweep in progress
f_in  input  1  F output of the function block under control
x  output  1  vector bit 2 to function block
y  output  1  vector bit 1
z  output  1  vector bit 0
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse at sweep completion
pass  output  1  high after a completed sweep with err_cnt == 0; held until next accepted start
err_cnt  output  4  number of mismatching vectors in the last sweep, 0..8
fail_vec  output  3  index of the first mismatching vector
fail_valid  output  1  fail_vec holds a valid index

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; x=y=z=0; busy=0; done=0; pass=0; err_cnt=0; fail_vec=0; fail_valid=0; vec index=0; dwell counter=0.
- All outputs are registered. x,y,z always equal the current vec index bits {2,1,0}.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 -> SETTLE.
  - On that transition: vec=0, dwell counter loaded with DWELL-1, busy=1, and err_cnt, fail_valid, fail_vec and pass all cleared.
- SETTLE:
  - Dwell counter decrements each cycle.
  - At 0 -> SAMPLE.
  - Occupies exactly DWELL cycles per vector.
- SAMPLE (1 cycle):
  - Compare f_in with EXP_TT[vec].
  - On mismatch: err_cnt += 1. If fail_valid=0, then fail_vec=vec and fail_valid=1.
  - If vec==7 -> DONE. Otherwise vec+=1, reload the dwell counter and go to SETTLE.
- DONE (1 cycle):
  - done=1, busy=0, pass=(err_cnt==0), x=y=z=0, vec=0.
  - Next state is IDLE unconditionally.
- Latency: if start is sampled at edge 0, done is high in the cycle following edge 8*(DWELL+1)+1. For DWELL=4 that is edge 41.
- Each vector is stable for DWELL+1 cycles. f_in is sampled on the last of these.
- start while busy (SETTLE/SAMPLE/DONE): ignored, no restart.
- abort in SETTLE or SAMPLE:
  - Next state IDLE; busy=0; x=y=z=0; no done pulse; pass=0.
  - err_cnt, fail_vec and fail_valid keep the values accumulated so far.
  - A compare in a SAMPLE cycle with abort=1 is discarded.
- abort in IDLE or DONE: no effect; the done pulse still occurs.
- start and abort together in IDLE: abort wins, no sweep starts.
- rst_n low mid-sweep: immediate return to reset values; no done pulse.
- err_cnt max is 8 and fits 4 bits; no saturation logic.
- vec wrap: vec never increments past 7 within a sweep; it is reset to 0 in DONE and on abort.

Test Plan:
- Reset: hold rst_n=0, toggle clk and start -> all outputs at reset values. Release rst_n mid-cycle -> outputs stay at reset values until the first start.
- Golden sweep: f_in driven by a correct x'z+xy' model, DWELL=4, start pulse at edge 0.
  - Required: x,y,z step 000..111, each held 5 cycles; done pulse after edge 41; pass=1; err_cnt=0; fail_valid=0.
- Faulty DUT, stuck-at-0: f_in=0 -> err_cnt=4, fail_vec=1, fail_valid=1, pass=0.
- Faulty DUT, inverted: f_in=~F -> err_cnt=8, fail_vec=0, pass=0.
- Abort mid-sweep: assert abort while vec=3 in SETTLE -> busy=0 and xyz=000 next cycle; no done; pass=0. Then issue start -> a full sweep runs with results cleared.
- Protocol edges:
  - start re-pulsed while busy -> done still at edge 41.
  - start and abort together in IDLE -> busy stays 0.
  - Re-parameterise DWELL=1 -> done after edge 17.
  - rst_n asserted at vec=5 -> immediate reset values, no done.

Source files
------------

// File: rtl/nor_sweep_ctrl.sv
// Sweeps {x,y,z} through 0..7 into the NOR function block, holds each vector
// for DWELL settle cycles, samples f_in and checks it against EXP_TT.
module nor_sweep_ctrl #(
    parameter int         DWELL  = 4,
    parameter logic [7:0] EXP_TT = 8'h3A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_vec,
    output logic       fail_valid
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state;
    logic [2:0]    vec;
    logic [CW-1:0] cnt;

    // vec is registered, so the drive lines are registered outputs too
    assign x = vec[2];
    assign y = vec[1];
    assign z = vec[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= 3'd0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 4'd0;
            fail_vec   <= 3'd0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state      <= S_SETTLE;
                        vec        <= 3'd0;
                        cnt        <= CW'(DWELL - 1);
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_cnt    <= 4'd0;
                        fail_vec   <= 3'd0;
                        fail_valid <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        vec   <= 3'd0;
                        pass  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // an aborted sample cycle drops its compare result
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        vec   <= 3'd0;
                        pass  <= 1'b0;
                    end else begin
                        if (f_in != EXP_TT[vec]) begin
                            err_cnt <= err_cnt + 4'd1;
                            if (!fail_valid) begin
                                fail_vec   <= vec;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (vec == 3'd7) begin
                            state <= S_DONE;
                        end else begin
                            vec   <= vec + 3'd1;
                            cnt   <= CW'(DWELL - 1);
                            state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_cnt == 4'd0);
                    vec   <= 3'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
